// File: rtl/directory_pfq_pkg.sv
// Shared types and constants for the directory prefetch queue (scmem request type, line geometry).
package directory_pfq_pkg;

    localparam int unsigned SC_LINE_OFFSET_BITS = 6;
    localparam int unsigned PADDR_W             = 40;
    localparam int unsigned LINE_W              = PADDR_W - SC_LINE_OFFSET_BITS;

    typedef enum logic [2:0] {
        CMD_PREF_RD = 3'd0,
        CMD_PREF_WR = 3'd1
    } pf_cmd_e;

    typedef struct packed {
        logic [4:0]         nid;
        logic [5:0]         l2id;
        pf_cmd_e            cmd;
        logic [PADDR_W-1:0] paddr;
    } I_l2todr_req_type;

endpackage

// File: rtl/directory_pfq_match.sv
// Line-address comparator across all queue entries, masked by entry occupancy.
import directory_pfq_pkg::*;

module directory_pfq_match #(
    parameter int unsigned ENTRIES = 8
) (
    input  logic [LINE_W-1:0]  line_i,
    input  logic [LINE_W-1:0]  lines_i [ENTRIES],
    input  logic [ENTRIES-1:0] valid_i,
    output logic               hit_o
);

    always_comb begin
        hit_o = 1'b0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (valid_i[i] && (lines_i[i] == line_i)) begin
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/directory_pfq.sv
// Drop-oldest prefetch request queue feeding the directory bank pfreq port.
// Optional duplicate-line filtering is enabled by defining DIRECTORY_PFQ_DEDUP_EN.
import directory_pfq_pkg::*;

module directory_pfq #(
    parameter int unsigned ENTRIES = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           l2todr_pfreq_valid,
    output logic                           l2todr_pfreq_retry,
    input  I_l2todr_req_type               l2todr_pfreq,
    output logic                           pfq_pfreq_valid,
    input  logic                           pfq_pfreq_retry,
    output I_l2todr_req_type               pfq_pfreq,
    output logic                           pfq_drop,
    output logic [$clog2(ENTRIES+1)-1:0]   pfq_count
);

    localparam int unsigned PW = $clog2(ENTRIES);
    localparam int unsigned CW = $clog2(ENTRIES + 1);

    I_l2todr_req_type mem_q [ENTRIES];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             drop_q, drop_d;

    logic full, deq, enq, dup;

    assign full = (count_q == CW'(ENTRIES));
    assign deq  = (count_q != '0) && !pfq_pfreq_retry;
    assign enq  = l2todr_pfreq_valid && !dup;

`ifdef DIRECTORY_PFQ_DEDUP_EN
    logic [LINE_W-1:0]  lines [ENTRIES];
    logic [ENTRIES-1:0] live;
    logic [PW-1:0]      off;

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        lines = '{default: '0};
        live  = '0;
        off   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            lines[i] = mem_q[i].paddr[PADDR_W-1:SC_LINE_OFFSET_BITS];
            off      = PW'(i) - head_q;
            live[i]  = (CW'(off) < count_q);
        end
    end

    directory_pfq_match #(.ENTRIES(ENTRIES)) u_match (
        .line_i  (l2todr_pfreq.paddr[PADDR_W-1:SC_LINE_OFFSET_BITS]),
        .lines_i (lines),
        .valid_i (live),
        .hit_o   (dup)
    );
`else
    assign dup = 1'b0;
`endif

    // Overflow advances head alongside tail so the oldest entry is overwritten.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        drop_d  = 1'b0;
        if (enq) begin
            tail_d = tail_q + PW'(1);
            if (!deq) begin
                if (full) begin
                    head_d = head_q + PW'(1);
                    drop_d = 1'b1;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
        end
        if (deq) begin
            head_d = head_q + PW'(1);
            if (!enq) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !reset) begin
            mem_q[tail_q] <= l2todr_pfreq;
        end
    end

    assign l2todr_pfreq_retry = reset;
    assign pfq_pfreq_valid    = (count_q != '0);
    assign pfq_pfreq          = mem_q[head_q];
    assign pfq_drop           = drop_q;
    assign pfq_count          = count_q;

endmodule
